// File: rtl/hazard_ctrl_vlat.sv
// hazard_ctrl_vlat: RV32 5-stage hazard unit with MEM/WB forwarding, variable-latency memory hold, load-use bubbles, flush gating and stall counter
// Inputs : clk, reset, inst_exec/inst_mem/inst_wb, reg_wr_mem/wb, mem_read/write/valid,
//          sel_for_branch, interupt_sel, perf_clr
// Outputs: forward_sel_1/2, flush_sel, stall, stall_mem, bubble, mem_timeout, stall_cycles
module hazard_ctrl_vlat #(
  parameter int TIMEOUT    = 64,
  parameter int LU_BUBBLES = 1,
  parameter int FWD_WB_EN  = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_exec,
  input  logic [31:0]      inst_mem,
  input  logic [31:0]      inst_wb,
  input  logic             reg_wr_mem,
  input  logic             reg_wr_wb,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_valid,
  input  logic             sel_for_branch,
  input  logic             interupt_sel,
  input  logic             perf_clr,
  output logic [1:0]       forward_sel_1,
  output logic [1:0]       forward_sel_2,
  output logic             flush_sel,
  output logic             stall,
  output logic             stall_mem,
  output logic             bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {NORMAL, MEM_WAIT, LU_BUBBLE} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);
  localparam bit LU_MULTI = LU_BUBBLES > 1;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [1:0] bub_cnt, bub_nxt;
  logic [CNT_W-1:0] cnt;
  logic st, sm, bu, to;
  logic [1:0] f1, f2;
  logic [4:0] rs1, rs2, rd_mem, rd_wb;
  logic acc, hit, mem_ok, wb_ok;
  logic unused_bits;
  assign rs1 = inst_exec[19:15];
  assign rs2 = inst_exec[24:20];
  assign rd_mem = inst_mem[11:7];
  assign rd_wb = inst_wb[11:7];
  assign unused_bits = ^{inst_exec[31:25], inst_exec[14:0], inst_mem[31:12], inst_mem[6:0], inst_wb[31:12], inst_wb[6:0]};
  assign acc = mem_read | mem_write;
  assign hit = mem_read & reg_wr_mem & (|rd_mem) & (rd_mem == rs1 | rd_mem == rs2);
  // A load in MEM has no result yet, so it is never a forwarding source.
  assign mem_ok = reg_wr_mem & ~mem_read & (|rd_mem);
  assign wb_ok = (FWD_WB_EN != 0) & reg_wr_wb & (|rd_wb);
  assign f1 = (mem_ok && rd_mem == rs1) ? 2'b01 : (wb_ok && rd_wb == rs1) ? 2'b10 : 2'b00;
  assign f2 = (mem_ok && rd_mem == rs2) ? 2'b01 : (wb_ok && rd_wb == rs2) ? 2'b10 : 2'b00;
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    bub_nxt = bub_cnt;
    st = 1'b0;
    sm = 1'b0;
    bu = 1'b0;
    to = 1'b0;
    case (state)
      NORMAL: begin
        if (acc && !mem_valid) begin
          st = 1'b1;
          sm = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt = WW'(1);
        end else if (hit) begin
          st = 1'b1;
          bu = 1'b1;
          state_nxt = LU_MULTI ? LU_BUBBLE : NORMAL;
          bub_nxt = LU_INIT;
        end
      end
      MEM_WAIT: begin
        if (mem_valid) begin
          st = hit;
          bu = hit;
          state_nxt = (hit && LU_MULTI) ? LU_BUBBLE : NORMAL;
          bub_nxt = LU_INIT;
        end else if (wait_cnt == TO_V) begin
          to = 1'b1;
          bu = 1'b1;
          state_nxt = NORMAL;
        end else begin
          st = 1'b1;
          sm = 1'b1;
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      LU_BUBBLE: begin
        st = 1'b1;
        bu = 1'b1;
        bub_nxt = bub_cnt - 2'd1;
        state_nxt = (bub_cnt == 2'd1) ? NORMAL : LU_BUBBLE;
      end
      default: state_nxt = NORMAL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
      wait_cnt <= '0;
      bub_cnt <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      bub_cnt <= bub_nxt;
      cnt <= perf_clr ? '0 : (st && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
    end
  end
  // Every output reads 0 while reset is held, including the registered counter.
  assign forward_sel_1 = reset ? 2'b00 : f1;
  assign forward_sel_2 = reset ? 2'b00 : f2;
  assign stall = ~reset & st;
  assign stall_mem = ~reset & sm;
  assign bubble = ~reset & bu;
  assign mem_timeout = ~reset & to;
  // Redirects are held by their sources, so masking during a stall only defers them.
  assign flush_sel = ~reset & (sel_for_branch | interupt_sel) & ~st;
  assign stall_cycles = reset ? '0 : cnt;
endmodule

// File: tb/tb_hazard_ctrl_vlat.sv
// tb_hazard_ctrl_vlat: scoreboard bench for hazard_ctrl_vlat with directed per-cycle vectors
module tb_hazard_ctrl_vlat;
  logic clk = 1'b1;
  logic reset, reg_wr_mem, reg_wr_wb, mem_read, mem_write, mem_valid;
  logic sel_for_branch, interupt_sel, perf_clr;
  logic [31:0] inst_exec, inst_mem, inst_wb;
  logic [1:0] forward_sel_1, forward_sel_2, fa_2, fb_2;
  logic flush_sel, stall, stall_mem, bubble, mem_timeout;
  logic fl_2, st_2, sm_2, bu_2, to_2;
  logic [3:0] stall_cycles, sc_2;
  typedef struct {
    logic [1:0] f1, f2;
    logic fl, st, sm, bu, to;
    logic [3:0] sc;
    logic c2, st2, bu2;
  } exp_t;
  exp_t q[$];
  exp_t mx;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  hazard_ctrl_vlat #(.TIMEOUT(4), .LU_BUBBLES(1), .FWD_WB_EN(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .inst_exec(inst_exec), .inst_mem(inst_mem), .inst_wb(inst_wb),
    .reg_wr_mem(reg_wr_mem), .reg_wr_wb(reg_wr_wb), .mem_read(mem_read), .mem_write(mem_write),
    .mem_valid(mem_valid), .sel_for_branch(sel_for_branch), .interupt_sel(interupt_sel),
    .perf_clr(perf_clr), .forward_sel_1(forward_sel_1), .forward_sel_2(forward_sel_2),
    .flush_sel(flush_sel), .stall(stall), .stall_mem(stall_mem), .bubble(bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles));
  hazard_ctrl_vlat #(.TIMEOUT(4), .LU_BUBBLES(2), .FWD_WB_EN(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .inst_exec(inst_exec), .inst_mem(inst_mem), .inst_wb(inst_wb),
    .reg_wr_mem(reg_wr_mem), .reg_wr_wb(reg_wr_wb), .mem_read(mem_read), .mem_write(mem_write),
    .mem_valid(mem_valid), .sel_for_branch(sel_for_branch), .interupt_sel(interupt_sel),
    .perf_clr(perf_clr), .forward_sel_1(fa_2), .forward_sel_2(fb_2),
    .flush_sel(fl_2), .stall(st_2), .stall_mem(sm_2), .bubble(bu_2),
    .mem_timeout(to_2), .stall_cycles(sc_2));
  function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'd0, rd, 7'h33};
  endfunction
  function automatic exp_t e(input logic [1:0] f1, input logic [1:0] f2, input logic fl, input logic st,
                             input logic sm, input logic bu, input logic to, input logic [3:0] sc);
    exp_t x;
    x.f1 = f1; x.f2 = f2; x.fl = fl; x.st = st; x.sm = sm; x.bu = bu; x.to = to; x.sc = sc;
    x.c2 = 1'b0; x.st2 = 1'b0; x.bu2 = 1'b0;
    return x;
  endfunction
  function automatic exp_t e2(input exp_t x, input logic st2, input logic bu2);
    exp_t y = x;
    y.c2 = 1'b1; y.st2 = st2; y.bu2 = bu2;
    return y;
  endfunction
  task automatic idle();
    inst_exec = '0; inst_mem = '0; inst_wb = '0;
    reg_wr_mem = 0; reg_wr_wb = 0; mem_read = 0; mem_write = 0; mem_valid = 0;
    sel_for_branch = 0; interupt_sel = 0; perf_clr = 0;
  endtask
  task automatic lw(input logic v);
    idle();
    inst_exec = rt(5'd3, 5'd1, 5'd2); inst_mem = rt(5'd7, 5'd0, 5'd0);
    reg_wr_mem = 1; mem_read = 1; mem_valid = v;
  endtask
  task automatic lu_hit();
    idle();
    inst_exec = rt(5'd8, 5'd7, 5'd1); inst_mem = rt(5'd7, 5'd0, 5'd0);
    reg_wr_mem = 1; mem_read = 1; mem_valid = 1;
  endtask
  task automatic step(input exp_t x);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h expected=%0h", n, cyc, a, r);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      cmp("forward_sel_1", 32'(forward_sel_1), 32'(mx.f1));
      cmp("forward_sel_2", 32'(forward_sel_2), 32'(mx.f2));
      cmp("flush_sel", 32'(flush_sel), 32'(mx.fl));
      cmp("stall", 32'(stall), 32'(mx.st));
      cmp("stall_mem", 32'(stall_mem), 32'(mx.sm));
      cmp("bubble", 32'(bubble), 32'(mx.bu));
      cmp("mem_timeout", 32'(mem_timeout), 32'(mx.to));
      cmp("stall_cycles", 32'(stall_cycles), 32'(mx.sc));
      if (mx.c2) begin
        cmp("lu2_stall", 32'(st_2), 32'(mx.st2));
        cmp("lu2_bubble", 32'(bu_2), 32'(mx.bu2));
      end
      cyc++;
    end
  end
  initial begin
    idle();
    reset = 1;
    inst_exec = rt(5'd6, 5'd5, 5'd5); inst_mem = rt(5'd5, 5'd0, 5'd0);
    reg_wr_mem = 1; mem_read = 1; sel_for_branch = 1;
    step(e(0, 0, 0, 0, 0, 0, 0, 0));
    // forwarding: MEM, MEM over WB, WB, x0, mixed
    idle(); reset = 0;
    inst_exec = rt(5'd6, 5'd5, 5'd5); inst_mem = rt(5'd5, 5'd0, 5'd0); reg_wr_mem = 1;
    step(e(2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    inst_wb = rt(5'd5, 5'd0, 5'd0); reg_wr_wb = 1;
    step(e(2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    inst_mem = rt(5'd0, 5'd0, 5'd0);
    step(e(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    inst_exec = rt(5'd1, 5'd0, 5'd0); inst_wb = rt(5'd0, 5'd0, 5'd0);
    step(e(0, 0, 0, 0, 0, 0, 0, 0));
    inst_exec = rt(5'd1, 5'd5, 5'd6); inst_mem = rt(5'd6, 5'd0, 5'd0); inst_wb = rt(5'd5, 5'd0, 5'd0);
    step(e(2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
    // memory wait of three stall cycles
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 0));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 1));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 2));
    lw(1); step(e(0, 0, 0, 0, 0, 0, 0, 3));
    // load-use, 1 vs 2 bubbles
    lu_hit(); step(e2(e(0, 0, 0, 1, 0, 1, 0, 3), 1, 1));
    idle(); inst_exec = rt(5'd8, 5'd7, 5'd1); inst_wb = rt(5'd7, 5'd0, 5'd0); reg_wr_wb = 1;
    step(e2(e(2'b10, 0, 0, 0, 0, 0, 0, 4), 1, 1));
    idle(); step(e2(e(0, 0, 0, 0, 0, 0, 0, 4), 0, 0));
    // branch held through a memory wait
    lw(0); sel_for_branch = 1; step(e(0, 0, 0, 1, 1, 0, 0, 4));
    lw(0); sel_for_branch = 1; step(e(0, 0, 0, 1, 1, 0, 0, 5));
    lw(1); sel_for_branch = 1; step(e(0, 0, 1, 0, 0, 0, 0, 6));
    idle(); interupt_sel = 1; step(e(0, 0, 1, 0, 0, 0, 0, 6));
    idle(); step(e(0, 0, 0, 0, 0, 0, 0, 6));
    // timeout after four MEM_WAIT cycles
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 6));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 7));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 8));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 9));
    lw(0); step(e(0, 0, 0, 0, 0, 1, 1, 10));
    idle(); step(e(0, 0, 0, 0, 0, 0, 0, 10));
    // reset in the middle of a wait
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 10));
    lw(0); step(e(0, 0, 0, 1, 1, 0, 0, 11));
    lw(0); reset = 1; sel_for_branch = 1; step(e(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); reset = 0; step(e(0, 0, 0, 0, 0, 0, 0, 0));
    // counter saturation and clear
    for (int i = 0; i < 17; i++) begin
      lu_hit(); step(e(0, 0, 0, 1, 0, 1, 0, (i < 15) ? 4'(i) : 4'd15));
    end
    lu_hit(); perf_clr = 1; step(e(0, 0, 0, 1, 0, 1, 0, 15));
    idle(); step(e(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
